// File: rtl/ind_status_ctrl.sv
// ind_status_ctrl
//   Master-side stage of the intf indication/status link. The slave drives the
//   asynchronous `ind` level. This block synchronizes and debounces it, and it
//   turns every qualified edge into a queued event. It then presents the
//   events one at a time on `status`. Each request is held until the local
//   logic acknowledges it or until it times out.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-high
//   ind_i        `ind` from the interface, asynchronous to clk
//   ack_i        local acknowledge of the current request (ignored outside REQ)
//   clr_i        clears the sticky overflow/timeout flags
//   status_o     `status` to the interface, high while a request is outstanding
//   pend_cnt_o   queued events not yet presented/acked (saturating)
//   event_cnt_o  total qualified events (wraps)
//   overflow_o   sticky: an event arrived while the pending counter was full
//   timeout_o    sticky: a request expired without an acknowledge
//
// Build option
//   IND_FALL_EVENT_EN  when defined, falling edges of the filtered level are
//                      events too. By default only rising edges count.

module ind_status_ctrl #(
  parameter int STABLE_CYCLES  = 4,
  parameter int CNT_W          = 4,
  parameter int TOT_W          = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ind_i,
  input  logic             ack_i,
  input  logic             clr_i,
  output logic             status_o,
  output logic [CNT_W-1:0] pend_cnt_o,
  output logic [TOT_W-1:0] event_cnt_o,
  output logic             overflow_o,
  output logic             timeout_o
);

  localparam int DW = $clog2(STABLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DW-1:0]    DB_LAST  = DW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          s1, s2;
  logic          filt, filt_d;
  logic [DW-1:0] db_cnt;
  logic [TW-1:0] timer, timer_n;
  logic          evt;
  logic          dec;
  logic          to_hit;
  logic          ovf_set;

  // Two-flop synchronizer followed by the debounce filter. The filtered
  // level follows s2 only after s2 has disagreed with it for STABLE_CYCLES
  // consecutive cycles. filt_d is the previous filtered level, which the
  // edge detector uses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1     <= ind_i;
      s2     <= s1;
      filt_d <= filt;
      if (s2 != filt) begin
        if (db_cnt == DB_LAST) begin
          filt   <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // An event is an edge of the filtered level. It takes effect in the
  // counters on the next clock edge.
`ifdef IND_FALL_EVENT_EN
  assign evt = filt ^ filt_d;
`else
  assign evt = filt & ~filt_d;
`endif

  // Request FSM: next state, timeout timer and dequeue strobe.
  // GAP returns straight to REQ when more events are queued. Back-to-back
  // requests are therefore separated by exactly one low cycle on status.
  always_comb begin
    state_n = state;
    timer_n = timer;
    dec     = 1'b0;
    to_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (pend_cnt_o != '0) begin
          state_n = REQ;
          timer_n = '0;
        end
      end
      REQ: begin
        timer_n = timer + TW'(1);
        if (ack_i) begin
          dec     = 1'b1;
          state_n = GAP;
        end else if (timer == TO_LAST) begin
          dec     = 1'b1;
          to_hit  = 1'b1;
          state_n = GAP;
        end
      end
      GAP: begin
        if (pend_cnt_o != '0) begin
          state_n = REQ;
          timer_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state register. status is registered from the next-state decode,
  // so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      status_o <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      status_o <= (state_n == REQ);
    end
  end

  // A full queue only overflows when no slot frees in the same cycle.
  assign ovf_set = evt && !dec && (pend_cnt_o == PEND_MAX);

  // Event counters and sticky flags. When a flag sets in the same cycle
  // that clr_i is high, the set takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt_o  <= '0;
      event_cnt_o <= '0;
      overflow_o  <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      if (evt) begin
        event_cnt_o <= event_cnt_o + TOT_W'(1);
      end

      if (evt && !dec) begin
        if (pend_cnt_o != PEND_MAX) begin
          pend_cnt_o <= pend_cnt_o + CNT_W'(1);
        end
      end else if (dec && !evt) begin
        pend_cnt_o <= pend_cnt_o - CNT_W'(1);
      end

      if (ovf_set) begin
        overflow_o <= 1'b1;
      end else if (clr_i) begin
        overflow_o <= 1'b0;
      end

      if (to_hit) begin
        timeout_o <= 1'b1;
      end else if (clr_i) begin
        timeout_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ind_status_ctrl.sv
// tb_ind_status_ctrl
//   Directed bench for ind_status_ctrl. Every expected value below was worked
//   out by hand from the intended cycle behaviour.
//   u_dut: STABLE_CYCLES=4, CNT_W=2, TIMEOUT_CYCLES=256. Used for latency,
//          glitch, saturation, back-to-back and reset tests.
//   u_to:  the same, but TIMEOUT_CYCLES=8. Used for the timeout tests.
//   Both instances share clk, rst and clr.
//   Inputs change 1ns after a rising edge, and outputs are sampled at the
//   same moment. The first edge after a change is "edge 0".

module tb_ind_status_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ind = 1'b0;
  logic        ack = 1'b0;
  logic        clr = 1'b0;
  logic        status;
  logic [1:0]  pend;
  logic [15:0] evt_cnt;
  logic        overflow;
  logic        timeout;

  logic        ind_to = 1'b0;
  logic        ack_to = 1'b0;
  logic        status_to;
  logic [1:0]  pend_to;
  logic [15:0] evt_cnt_to;
  logic        overflow_to;
  logic        timeout_to;

  int vec_count  = 0;
  int miss_count = 0;
  int hi_count;

  always #5 clk = ~clk;

  ind_status_ctrl #(
    .STABLE_CYCLES (4),
    .CNT_W         (2),
    .TOT_W         (16),
    .TIMEOUT_CYCLES(256)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .ind_i      (ind),
    .ack_i      (ack),
    .clr_i      (clr),
    .status_o   (status),
    .pend_cnt_o (pend),
    .event_cnt_o(evt_cnt),
    .overflow_o (overflow),
    .timeout_o  (timeout)
  );

  ind_status_ctrl #(
    .STABLE_CYCLES (4),
    .CNT_W         (2),
    .TOT_W         (16),
    .TIMEOUT_CYCLES(8)
  ) u_to (
    .clk        (clk),
    .rst        (rst),
    .ind_i      (ind_to),
    .ack_i      (ack_to),
    .clr_i      (clr),
    .status_o   (status_to),
    .pend_cnt_o (pend_to),
    .event_cnt_o(evt_cnt_to),
    .overflow_o (overflow_to),
    .timeout_o  (timeout_to)
  );

  // Advance n clock edges and land 1ns after the last one.
  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive the u_dut inputs and the shared clr, then advance n cycles.
  task automatic applyStimulus(input logic i_ind, input logic i_ack,
                               input logic i_clr, input int n);
    ind = i_ind;
    ack = i_ack;
    clr = i_clr;
    waitCycles(n);
  endtask

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
    vec_count++;
    if (got !== want) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  initial begin
    // Reset state.
    waitCycles(3);
    checkOutput("rst_status",   32'(status),   0);
    checkOutput("rst_pend",     32'(pend),     0);
    checkOutput("rst_evtcnt",   32'(evt_cnt),  0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_timeout",  32'(timeout),  0);

    // Latency: ind is sampled high at edge 0, the event lands at edge 6,
    // and status rises at edge 7. ack is raised 3 cycles after status rises.
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 7);
    checkOutput("lat_status_e6", 32'(status),  0);
    checkOutput("lat_evtcnt_e6", 32'(evt_cnt), 1);
    checkOutput("lat_pend_e6",   32'(pend),    1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("lat_status_e7", 32'(status),  1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("lat_status_e9", 32'(status),  1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("ack_gap_status", 32'(status),  0);
    checkOutput("ack_pend",       32'(pend),    0);
    checkOutput("ack_timeout",    32'(timeout), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("ack_idle_status", 32'(status), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4);
    checkOutput("ack_stays_low",  32'(status),  0);
    checkOutput("ack_evtcnt",     32'(evt_cnt), 1);

    // A 3-cycle glitch is shorter than STABLE_CYCLES and must be ignored.
    applyStimulus(1'b0, 1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 10);
    checkOutput("glitch_evtcnt", 32'(evt_cnt), 1);
    checkOutput("glitch_status", 32'(status),  0);
    checkOutput("glitch_pend",   32'(pend),    0);

    // Five debounced pulses with no ack. The 2-bit pending counter saturates
    // at 3, and the 4th event sets overflow.
    for (int p = 1; p <= 5; p++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 6);
      applyStimulus(1'b0, 1'b0, 1'b0, 6);
      if (p == 3) begin
        checkOutput("sat3_pend",     32'(pend),     3);
        checkOutput("sat3_overflow", 32'(overflow), 0);
      end
      if (p == 4) begin
        checkOutput("sat4_pend",     32'(pend),     3);
        checkOutput("sat4_overflow", 32'(overflow), 1);
      end
    end
    checkOutput("sat5_evtcnt", 32'(evt_cnt), 6);
    checkOutput("sat5_status", 32'(status),  1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("clr_overflow", 32'(overflow), 0);
    checkOutput("clr_pend",     32'(pend),     3);
    checkOutput("clr_status",   32'(status),   1);

    // Drain the queue with an ack on the first REQ cycle each time. There
    // is exactly one low cycle between back-to-back requests.
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("b2b_gap1",  32'(status), 0);
    checkOutput("b2b_pend2", 32'(pend),   2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("b2b_req2",  32'(status), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("b2b_gap2",  32'(status), 0);
    checkOutput("b2b_pend1", 32'(pend),   1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("b2b_req3",  32'(status), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("b2b_gap3",  32'(status), 0);
    checkOutput("b2b_pend0", 32'(pend),   0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("b2b_idle",    32'(status),  0);
    checkOutput("b2b_timeout", 32'(timeout), 0);

    // Timeout on u_to: status stays high for exactly 8 cycles, then
    // timeout sets and the event is dropped.
    ind_to = 1'b1;
    waitCycles(8);
    hi_count = 0;
    for (int i = 0; i < 20; i++) begin
      if (!status_to) break;
      hi_count++;
      waitCycles(1);
    end
    checkOutput("to_high_cycles", 32'(hi_count),   8);
    checkOutput("to_flag",        32'(timeout_to), 1);
    checkOutput("to_pend",        32'(pend_to),    0);
    checkOutput("to_status",      32'(status_to),  0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    clr = 1'b0;
    checkOutput("to_clr", 32'(timeout_to), 0);

    // Same again, but with an ack in the 8th REQ cycle. The ack wins.
    ind_to = 1'b0;
    waitCycles(8);
    ind_to = 1'b1;
    waitCycles(8);
    checkOutput("to2_status_c1", 32'(status_to), 1);
    waitCycles(7);
    checkOutput("to2_status_c8", 32'(status_to), 1);
    ack_to = 1'b1;
    waitCycles(1);
    ack_to = 1'b0;
    checkOutput("to2_flag",   32'(timeout_to), 0);
    checkOutput("to2_status", 32'(status_to),  0);
    checkOutput("to2_pend",   32'(pend_to),    0);
    checkOutput("to2_evtcnt", 32'(evt_cnt_to), 2);

    // Reset during REQ while ind stays high. After release, the held level
    // is a fresh event, and status rises at edge 7.
    applyStimulus(1'b1, 1'b0, 1'b0, 8);
    checkOutput("mid_req_status", 32'(status), 1);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("mid_rst_status",   32'(status),   0);
    checkOutput("mid_rst_pend",     32'(pend),     0);
    checkOutput("mid_rst_evtcnt",   32'(evt_cnt),  0);
    checkOutput("mid_rst_overflow", 32'(overflow), 0);
    checkOutput("mid_rst_timeout",  32'(timeout),  0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 7);
    checkOutput("post_rst_status_e6", 32'(status),  0);
    checkOutput("post_rst_evtcnt",    32'(evt_cnt), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("post_rst_status_e7", 32'(status),  1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
